// File: rtl/fw_loader_pkg.sv
// Shared types and constants for the firmware loader.
package fw_loader_pkg;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/fw_loader_if.sv
// Byte-source and memory-write-port bundle for fw_loader.
interface fw_loader_if
  import fw_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) ();

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fw_word_assembler.sv
// Little-endian byte-to-word assembler; word_valid fires in the cycle the last byte arrives.
module fw_word_assembler
  import fw_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-9:0] shift_q, shift_d;

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = byte_valid && (cnt_q == CNT_W'(WORD_BYTES - 1));
    // earlier bytes sit in the low lanes, so the arriving byte completes the top lane
    word       = {byte_data, shift_q};
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 1'b1;
      shift_d = {byte_data, shift_q[DATA_W-9:8]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/fw_loader.sv
// Front-door firmware loader: length header, N little-endian words, core held in reset until done.
// Optional trailing XOR checksum when FW_LOADER_CHECKSUM_EN is defined.
module fw_loader
  import fw_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  fw_loader_if.master bus,
  output logic       core_reset_n,
  output logic       done,
  output logic       error
);

  localparam int CNT_W = ADDR_W + 1;

`ifdef FW_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER_DATA = S_CSUM;
`else
  localparam state_e S_AFTER_DATA = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_rst_n_q, core_rst_n_d;
`ifdef FW_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic              byte_fire;
  logic              asm_clear;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  assign byte_fire = bus.rx_valid & rx_ready_q;
  // Counters already sit at zero on every field boundary; the clear keeps fields independent.
  assign asm_clear = (state_d != state_q);

  fw_word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (asm_clear),
    .byte_valid (byte_fire),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef FW_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_LEN: begin
        if (word_valid) begin
          if (word == '0) begin
            state_d = S_AFTER_DATA;
          end else if (word > DATA_W'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            len_d   = word[CNT_W-1:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Leave S_DATA as the last word completes; its write strobe lands in the next cycle.
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(BASE_ADDR) + word_idx_q[ADDR_W-1:0];
          mem_wdata_d = word;
          word_idx_d  = word_idx_q + CNT_W'(1);
`ifdef FW_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ word;
`endif
          if (word_idx_d == len_q) state_d = S_AFTER_DATA;
        end
      end
`ifdef FW_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (word_valid) state_d = (word == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase

    rx_ready_d   = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d       = done_q | (state_q == S_DONE);
    core_rst_n_d = core_rst_n_q | (state_q == S_DONE);
    error_d      = error_q | (state_q == S_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LEN;
      len_q        <= '0;
      word_idx_q   <= '0;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
`ifdef FW_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
`ifdef FW_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign error         = error_q;
  assign core_reset_n  = core_rst_n_q;

endmodule

// File: tb/tb_fw_loader.sv
// Scoreboard bench for fw_loader: expected writes queued by the image model, popped by a write monitor.
module tb_fw_loader;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int MAX_WORDS = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic core_reset_n, done, error;

  fw_loader_if #(.ADDR_W(ADDR_W)) bus ();

  fw_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  wr_t         exp_q[$];
  logic [31:0] img_words[$];

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && bus.mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
          errors++;
          $display("FAIL mem_write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned t;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    while (!bus.rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 200 cycles, required 1");
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  function automatic logic [31:0] ref_xor(input int unsigned n);
    logic [31:0] x = '0;
    for (int unsigned i = 0; i < n; i++) x ^= img_words[i];
    return x;
  endfunction

  // Loads header n followed by img_words (and checksum when enabled); checks final outputs.
  task automatic run_image(input logic [31:0] n, input bit gaps, input logic [31:0] csum_val);
    bit ok;
    wr_t w;
    do_reset();
    ok = (n <= MAX_WORDS);
`ifdef FW_LOADER_CHECKSUM_EN
    if (ok && csum_val != ref_xor(n)) ok = 1'b0;
`else
    if (csum_val === 32'hx) ok = 1'b0;
`endif
    if (n <= MAX_WORDS) begin
      for (int unsigned i = 0; i < n; i++) begin
        w.addr = ADDR_W'(BASE_ADDR + i);
        w.data = img_words[i];
        exp_q.push_back(w);
      end
    end
    send_word(n, gaps);
    if (n <= MAX_WORDS) begin
      for (int unsigned i = 0; i < n; i++) send_word(img_words[i], gaps);
`ifdef FW_LOADER_CHECKSUM_EN
      send_word(csum_val, gaps);
`endif
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("done", {31'b0, done}, {31'b0, ok});
    chk("error", {31'b0, error}, {31'b0, !ok});
    chk("core_reset_n", {31'b0, core_reset_n}, {31'b0, ok});
    chk("rx_ready_final", {31'b0, bus.rx_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("pending_writes", exp_q.size(), 32'd0);
    chk("done_sticky", {31'b0, done}, {31'b0, ok});
    exp_q.delete();
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_core_reset_n", {31'b0, core_reset_n}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);

    img_words = '{32'h12345678, 32'hDEADBEEF};
    run_image(32'd2, 1'b0, ref_xor(2));
    run_image(32'd0, 1'b0, 32'd0);
    run_image(32'd1025, 1'b0, 32'd0);
    run_image(32'd2, 1'b1, ref_xor(2));

    // Reset after six data bytes: only the first word may reach memory.
    begin
      wr_t w;
      do_reset();
      w.addr = ADDR_W'(BASE_ADDR);
      w.data = img_words[0];
      exp_q.push_back(w);
      send_word(32'd2, 1'b0);
      send_word(img_words[0], 1'b0);
      send_byte(img_words[1][7:0], 1'b0);
      send_byte(img_words[1][15:8], 1'b0);
      bus.rx_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midrst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
      chk("midrst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      chk("midrst_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
      chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("midrst_core_reset_n", {31'b0, core_reset_n}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_pending", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
      run_image(32'd2, 1'b0, ref_xor(2));
    end

`ifdef FW_LOADER_CHECKSUM_EN
    run_image(32'd2, 1'b0, 32'h00000000);
`endif

    for (int r = 0; r < 5; r++) begin
      int unsigned n;
      n = $urandom_range(6, 1);
      img_words.delete();
      for (int unsigned i = 0; i < n; i++) img_words.push_back($urandom());
      run_image(n, ($urandom_range(1, 0) == 1), ref_xor(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
